// File: rtl/fir_decimate_param_if.sv
// Sample stream, coefficient port and status bundle between the receive
// chain and fir_decimate_param.
`timescale 1ns/1ps
interface fir_decimate_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 16,
    parameter int MAX_DECIM  = 8
);
    logic                                 single_valid_in;
    logic signed [DATA_WIDTH-1:0]         data_in;
    logic                                 in_ready;
    logic [$clog2(MAX_DECIM+1)-1:0]       decim_sel;
    logic                                 coef_wr_en;
    logic [$clog2(TAPS)-1:0]              coef_addr;
    logic signed [COEF_WIDTH-1:0]         coef_data;
    logic                                 fad_valid_out;
    logic signed [DATA_WIDTH-1:0]         fad_data_out;
    logic                                 overrun;
    logic                                 overrun_clr;

    modport master (
        output single_valid_in, data_in, decim_sel, coef_wr_en, coef_addr,
               coef_data, overrun_clr,
        input  in_ready, fad_valid_out, fad_data_out, overrun
    );

    modport slave (
        input  single_valid_in, data_in, decim_sel, coef_wr_en, coef_addr,
               coef_data, overrun_clr,
        output in_ready, fad_valid_out, fad_data_out, overrun
    );
endinterface

// File: rtl/fir_decimate_param.sv
// Runtime-programmable FIR low-pass fused with an integer decimator; a single
// time-shared MAC runs only on the sample that closes each decimation group.
`timescale 1ns/1ps
module fir_decimate_param #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 14,
    parameter int TAPS       = 16,
    parameter int MAX_DECIM  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_decimate_param_if.slave   bus
);
    localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS);
    localparam int TAP_W = $clog2(TAPS);
    localparam int RAT_W = $clog2(MAX_DECIM + 1);

    localparam logic signed [ACC_W-1:0]      ROUND_HALF = ACC_W'(64'sd1 <<< (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0]      SAT_MAX    = ACC_W'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0]      SAT_MIN    = ~SAT_MAX;
    localparam logic signed [COEF_WIDTH-1:0] COEF_ONE   = COEF_WIDTH'(64'sd1 <<< COEF_FRAC);

    typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

    state_t                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] delay_q [TAPS];
    logic signed [DATA_WIDTH-1:0] delay_d [TAPS];
    logic signed [COEF_WIDTH-1:0] coef_q  [TAPS];
    logic signed [COEF_WIDTH-1:0] coef_d  [TAPS];
    logic [RAT_W-1:0]             phase_q, phase_d;
    logic [RAT_W-1:0]             ratio_q, ratio_d;
    logic [TAP_W-1:0]             tap_q, tap_d;
    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic                         in_ready_q, in_ready_d;
    logic                         valid_q, valid_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                         overrun_q, overrun_d;

    logic                         accept;
    logic [RAT_W-1:0]             group_ratio;
    logic signed [ACC_W-1:0]      product;
    logic signed [ACC_W-1:0]      round_sum;
    logic signed [ACC_W-1:0]      rounded;
    logic signed [DATA_WIDTH-1:0] sample_sat;

    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        coef_d     = coef_q;
        phase_d    = phase_q;
        ratio_d    = ratio_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        in_ready_d = in_ready_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        overrun_d  = overrun_q;

        accept = bus.single_valid_in && in_ready_q;

        // The ratio is latched from decim_sel only on the first sample of a group.
        group_ratio = ratio_q;
        if (phase_q == '0) begin
            if (bus.decim_sel == '0)
                group_ratio = RAT_W'(1);
            else if (bus.decim_sel > RAT_W'(MAX_DECIM))
                group_ratio = RAT_W'(MAX_DECIM);
            else
                group_ratio = bus.decim_sel;
        end

        product   = ACC_W'(coef_q[tap_q]) * ACC_W'(delay_q[tap_q]);
        round_sum = acc_q + ROUND_HALF;
        rounded   = round_sum >>> COEF_FRAC;
        if (rounded > SAT_MAX)
            sample_sat = DATA_WIDTH'(SAT_MAX);
        else if (rounded < SAT_MIN)
            sample_sat = DATA_WIDTH'(SAT_MIN);
        else
            sample_sat = DATA_WIDTH'(rounded);

        if (bus.single_valid_in && !in_ready_q)
            overrun_d = 1'b1;
        else if (bus.overrun_clr)
            overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.coef_wr_en) begin
                    for (int i = 0; i < TAPS; i++) begin
                        if (bus.coef_addr == TAP_W'(i))
                            coef_d[i] = bus.coef_data;
                    end
                end
                if (accept) begin
                    delay_d[0] = bus.data_in;
                    for (int i = 1; i < TAPS; i++)
                        delay_d[i] = delay_q[i-1];
                    ratio_d = group_ratio;
                    if (phase_q == group_ratio - RAT_W'(1)) begin
                        phase_d    = '0;
                        state_d    = MAC;
                        in_ready_d = 1'b0;
                        acc_d      = '0;
                        tap_d      = '0;
                    end else begin
                        phase_d = phase_q + RAT_W'(1);
                    end
                end
            end
            MAC: begin
                acc_d = acc_q + product;
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == TAP_W'(TAPS - 1))
                    state_d = ROUND;
            end
            ROUND: begin
                data_d  = sample_sat;
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // Reset leaves a pass-through filter: unity on tap 0, every other tap zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            for (int i = 0; i < TAPS; i++) begin
                delay_q[i] <= '0;
                coef_q[i]  <= (i == 0) ? COEF_ONE : '0;
            end
            phase_q    <= '0;
            ratio_q    <= RAT_W'(1);
            tap_q      <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b1;
            valid_q    <= 1'b0;
            data_q     <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            coef_q     <= coef_d;
            phase_q    <= phase_d;
            ratio_q    <= ratio_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.fad_valid_out = valid_q;
    assign bus.fad_data_out  = data_q;
    assign bus.overrun       = overrun_q;

endmodule
